// File: rtl/aes_cipher_wide.sv
// LANES x AES-128 encrypt datapath with ready/valid backpressure, credit flow control and an
// output FIFO for in-flight blocks. Define AES_CTR_MODE_EN for AES-CTR; otherwise ECB.

module aes_cipher_128_pipe (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key,
    input  logic [127:0] din,
    output logic [127:0] dout
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? x : 8'h00);
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box = affine map of the GF(2^8) inverse, computed as b^254 (0 maps to 0)
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] r;
        p = b;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [1407:0] expand_key(input logic [127:0] k);
        logic [127:0]  prev;
        logic [31:0]   w0, w1, w2, w3;
        logic [7:0]    rcon;
        logic [1407:0] all;
        all  = {1280'h0, k};
        prev = k;
        rcon = 8'h01;
        for (int r = 1; r < 11; r++) begin
            w0   = prev[127:96] ^ sub_word({prev[23:0], prev[31:24]}) ^ {rcon, 24'h000000};
            w1   = prev[95:64] ^ w0;
            w2   = prev[63:32] ^ w1;
            w3   = prev[31:0] ^ w2;
            prev = {w0, w1, w2, w3};
            all[128*r +: 128] = prev;
            rcon = xtime(rcon);
        end
        return all;
    endfunction

    // Byte 0 is the most significant byte; column c holds bytes 4c..4c+3
    function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c+r] = b[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            a0 = t[4*c];
            a1 = t[4*c+1];
            a2 = t[4*c+2];
            a3 = t[4*c+3];
            o[127-32*c -: 32] = last ? {a0, a1, a2, a3} :
                {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o ^ rk;
    endfunction

    logic [1407:0] rk_all_s;
    logic [127:0]  st_r [11];

    assign rk_all_s = expand_key(key);

    // Stage 0 is the initial AddRoundKey, stages 1..10 the rounds; no stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 11; i++) st_r[i] <= 128'h0;
        end else begin
            st_r[0] <= din ^ rk_all_s[127:0];
            for (int i = 1; i < 11; i++)
                st_r[i] <= enc_round(st_r[i-1], rk_all_s[128*i +: 128], (i == 10));
        end
    end

    assign dout = st_r[10];
endmodule

module aes_cipher_wide_chk #(
    parameter int FIFO_DEPTH = 16,
    parameter int AW         = 4,
    parameter int CW         = 5
) (
    input logic          clk,
    input logic          rst,
    input logic          wr,
    input logic [AW:0]   count,
    input logic [CW-1:0] credits
);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(wr && (count == (AW+1)'(FIFO_DEPTH))));
    a_credit_range: assert property (@(posedge clk) disable iff (!rst)
        credits <= CW'(FIFO_DEPTH));
endmodule

module aes_cipher_wide #(
    parameter int LANES      = 4,
    parameter int CORE_LAT   = 11,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [127:0]         key,
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    input  logic [128*LANES-1:0] data_in,
    output logic                 data_out_valid,
    input  logic                 data_out_ready,
    output logic [128*LANES-1:0] data_out,
    output logic                 busy
`ifdef AES_CTR_MODE_EN
    ,
    input  logic [127:0]         ctr_init,
    input  logic                 ctr_ld
`endif
);
    localparam int W  = 128*LANES;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [CW-1:0]       credits_r, credits_nxt_s;
    logic [AW:0]         count_r, count_nxt_s;
    logic [AW-1:0]       wr_ptr_r, rd_ptr_r, rd_ptr_nxt_s;
    logic [W-1:0]        mem_r [FIFO_DEPTH];
    logic [CORE_LAT-1:0] vpipe_r;
    logic [W-1:0]        core_in_s, core_out_s, wdata_s, out_data_r;
    logic                accept_s, pop_s, wr_s;
    logic                in_ready_r, out_valid_r, busy_r;

    assign accept_s = data_in_valid && in_ready_r;
    assign pop_s    = out_valid_r && data_out_ready;
    assign wr_s     = vpipe_r[CORE_LAT-1];

`ifdef AES_CTR_MODE_EN
    logic [127:0] ctr_r;
    logic [W-1:0] dly_r [CORE_LAT];

    // Counter: an accept uses the current value; a same-cycle load overrides the advance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          ctr_r <= 128'h0;
        else if (ctr_ld)   ctr_r <= ctr_init;
        else if (accept_s) ctr_r <= {ctr_r[127:32], ctr_r[31:0] + 32'(LANES)};
        else               ctr_r <= ctr_r;
    end

    // Plaintext delay line running in step with the cores
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CORE_LAT; i++) dly_r[i] <= {W{1'b0}};
        end else begin
            dly_r[0] <= data_in;
            for (int i = 1; i < CORE_LAT; i++) dly_r[i] <= dly_r[i-1];
        end
    end

    // Per-lane counter blocks; only the low word advances, wrapping mod 2^32
    always_comb begin
        core_in_s = {W{1'b0}};
        for (int i = 0; i < LANES; i++)
            core_in_s[128*i +: 128] = {ctr_r[127:32], ctr_r[31:0] + 32'(i)};
    end

    assign wdata_s = core_out_s ^ dly_r[CORE_LAT-1];
`else
    assign core_in_s = data_in;
    assign wdata_s   = core_out_s;
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        aes_cipher_128_pipe u_core (
            .clk  (clk),
            .rst  (rst),
            .key  (key),
            .din  (core_in_s[128*g +: 128]),
            .dout (core_out_s[128*g +: 128])
        );
    end

    // Next credit count, FIFO occupancy and read pointer
    always_comb begin
        credits_nxt_s = credits_r;
        count_nxt_s   = count_r;
        rd_ptr_nxt_s  = rd_ptr_r;
        if (accept_s && !pop_s)      credits_nxt_s = credits_r - CW'(1);
        else if (pop_s && !accept_s) credits_nxt_s = credits_r + CW'(1);
        else                         credits_nxt_s = credits_r;
        if (wr_s && !pop_s)          count_nxt_s = count_r + (AW+1)'(1);
        else if (pop_s && !wr_s)     count_nxt_s = count_r - (AW+1)'(1);
        else                         count_nxt_s = count_r;
        if (pop_s)                   rd_ptr_nxt_s = rd_ptr_r + AW'(1);
        else                         rd_ptr_nxt_s = rd_ptr_r;
    end

    // Control state and registered outputs; the head bypasses a block written this cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credits_r   <= DEPTH_C;
            count_r     <= {(AW+1){1'b0}};
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            vpipe_r     <= {CORE_LAT{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            out_data_r  <= {W{1'b0}};
        end else begin
            credits_r   <= credits_nxt_s;
            count_r     <= count_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            wr_ptr_r    <= wr_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
            vpipe_r     <= {vpipe_r[CORE_LAT-2:0], accept_s};
            in_ready_r  <= (credits_nxt_s != {CW{1'b0}});
            busy_r      <= (credits_nxt_s != DEPTH_C);
            out_valid_r <= (count_nxt_s != {(AW+1){1'b0}});
            if (count_nxt_s == {(AW+1){1'b0}})          out_data_r <= {W{1'b0}};
            else if (wr_s && (rd_ptr_nxt_s == wr_ptr_r)) out_data_r <= wdata_s;
            else                                         out_data_r <= mem_r[rd_ptr_nxt_s];
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (wr_s) mem_r[wr_ptr_r] <= wdata_s;
    end

    assign data_in_ready  = in_ready_r;
    assign data_out_valid = out_valid_r;
    assign data_out       = out_data_r;
    assign busy           = busy_r;

    aes_cipher_wide_chk #(.FIFO_DEPTH(FIFO_DEPTH), .AW(AW), .CW(CW)) u_chk (
        .clk     (clk),
        .rst     (rst),
        .wr      (wr_s),
        .count   (count_r),
        .credits (credits_r)
    );
endmodule

// File: tb/tb_aes_cipher_wide.sv
// Randomized bench for aes_cipher_wide against a table-driven AES and a queue-based flow model.
`timescale 1ns/1ps
module tb_aes_cipher_wide;
    localparam int LANES = 4, CORE_LAT = 11, FIFO_DEPTH = 16, W = 128*LANES;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key;
    logic         data_in_valid, data_in_ready, data_out_valid, data_out_ready, busy;
    logic [W-1:0] data_in, data_out;
`ifdef AES_CTR_MODE_EN
    logic [127:0] ctr_init, init_req;
    logic         ctr_ld, ld_req;
`endif

    always #5 clk = ~clk;

    aes_cipher_wide #(.LANES(LANES), .CORE_LAT(CORE_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .key            (key),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_in        (data_in),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .data_out       (data_out),
        .busy           (busy)
`ifdef AES_CTR_MODE_EN
        ,
        .ctr_init       (ctr_init),
        .ctr_ld         (ctr_ld)
`endif
    );

    typedef struct { logic [W-1:0] data; int due; } beat_t;

    int           n_checks = 0, n_errors = 0;
    logic [7:0]   sb [256];
    beat_t        exp_q [$];
    int           pop_log [$];
    int           cyc = 0, outstanding = 0, n_acc = 0, n_pop = 0;
    logic [W-1:0] last_out;
    logic [127:0] ctr_m = 128'h0;

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mul2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box table from the generator walk: p steps by x3, q by /3
    task automatic init_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ mul2(p);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 44; i++) begin
            if (i < 4) w[i] = k[127-32*i -: 32];
            else begin
                tmp = w[i-1];
                if (i % 4 == 0) begin
                    tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                    rc = mul2(rc);
                end
                w[i] = w[i-4] ^ tmp;
            end
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[4*(((i/4)+(i%4))%4) + i%4]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[4*c+r] = (rnd == 10) ? t[4*c+r] :
                        mul2(t[4*c+r]) ^ mul2(t[4*c+(r+1)%4]) ^ t[4*c+(r+1)%4] ^
                        t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [W-1:0] expect_beat(input logic [W-1:0] d, input logic [127:0] ctr);
        logic [W-1:0] e;
        for (int i = 0; i < LANES; i++) begin
`ifdef AES_CTR_MODE_EN
            e[128*i +: 128] = aes_ref(key, {ctr[127:32], ctr[31:0] + 32'(i)}) ^ d[128*i +: 128];
`else
            e[128*i +: 128] = aes_ref(key, d[128*i +: 128]) ^ {96'h0, ctr[31:0] & 32'h0};
`endif
        end
        return e;
    endfunction

    function automatic logic [W-1:0] rand_beat();
        logic [W-1:0] v;
        for (int i = 0; i < W/32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // One clock: drive at negedge, check registered outputs, then update the model
    task automatic cycle(input logic iv, input logic [W-1:0] d, input logic ordy);
        logic  acc, pop, exp_valid;
        beat_t b;
        @(negedge clk);
        data_in_valid  = iv;
        data_in        = d;
        data_out_ready = ordy;
`ifdef AES_CTR_MODE_EN
        ctr_ld   = ld_req;
        ctr_init = init_req;
`endif
        check_eq("in_ready", W'(data_in_ready), W'(outstanding < FIFO_DEPTH));
        check_eq("busy", W'(busy), W'(outstanding != 0));
        exp_valid = (exp_q.size() != 0) && (exp_q[0].due <= cyc);
        check_eq("out_valid", W'(data_out_valid), W'(exp_valid));
        if (!data_out_valid) check_eq("out_zero", data_out, {W{1'b0}});
        pop = data_out_valid && ordy;
        if (pop) begin
            if (exp_q.size() != 0) begin
                check_eq("out_data", data_out, exp_q[0].data);
                void'(exp_q.pop_front());
            end else begin
                check_eq("out_unexpected", W'(data_out_valid), {W{1'b0}});
            end
            last_out = data_out;
            outstanding--;
            n_pop++;
            pop_log.push_back(cyc);
        end
        acc = iv && data_in_ready;
        if (acc) begin
            b.data = expect_beat(d, ctr_m);
            b.due  = cyc + CORE_LAT + 1;
            exp_q.push_back(b);
            outstanding++;
            n_acc++;
        end
`ifdef AES_CTR_MODE_EN
        if (ld_req)   ctr_m = init_req;
        else if (acc) ctr_m[31:0] = ctr_m[31:0] + 32'(LANES);
`endif
        cyc++;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] v, exp1;
        int a0, p0, lat, guard;
        logic got;
        init_sbox();
        rst = 1'b1; key = 128'h0; data_in_valid = 1'b0; data_in = {W{1'b0}}; data_out_ready = 1'b0;
`ifdef AES_CTR_MODE_EN
        ctr_ld = 1'b0; ctr_init = 128'h0; ld_req = 1'b0; init_req = 128'h0;
`endif
        #1 rst = 1'b0;
        #10;
        check_eq("rst_in_ready", W'(data_in_ready), W'(1'b1));
        check_eq("rst_busy", W'(busy), W'(1'b0));
        check_eq("rst_out_valid", W'(data_out_valid), W'(1'b0));
        check_eq("rst_out_data", data_out, {W{1'b0}});
        @(negedge clk) rst = 1'b1;

`ifndef AES_CTR_MODE_EN
        // Known-answer beat and first-valid latency
        v = {W{1'b0}};
        v[255:128] = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
        exp1 = {128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                128'hf795bd4a52e29ed713d313fa20e98dbc, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        cycle(1'b1, v, 1'b1);
        lat = 0; got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            cycle(1'b0, {W{1'b0}}, 1'b1);
            lat++;
            got = data_out_valid;
        end
        check_eq("t1_latency", W'(lat - 1), W'(CORE_LAT));
        check_eq("t1_kat", last_out, exp1);
`endif

        // Backpressure fills exactly FIFO_DEPTH credits, then drains in order
        key = {$urandom, $urandom, $urandom, $urandom};
        a0 = n_acc; p0 = n_pop;
        for (int i = 0; i < 40; i++) cycle(1'b1, rand_beat(), 1'b0);
        check_eq("t2_accepted", W'(n_acc - a0), W'(FIFO_DEPTH));
        check_eq("t2_ready_low", W'(data_in_ready), W'(1'b0));
        for (int i = 0; i < 40; i++) cycle(1'b0, {W{1'b0}}, 1'b1);
        check_eq("t2_popped", W'(n_pop - p0), W'(FIFO_DEPTH));

        // Streaming 100 beats back to back
        a0 = n_acc; p0 = n_pop;
        pop_log.delete();
        for (int i = 0; i < 100; i++) cycle(1'b1, rand_beat(), 1'b1);
        check_eq("t3_accepted", W'(n_acc - a0), W'(100));
        for (int i = 0; i < 30; i++) cycle(1'b0, {W{1'b0}}, 1'b1);
        check_eq("t3_popped", W'(n_pop - p0), W'(100));
        if (pop_log.size() == 100) check_eq("t3_consecutive", W'(pop_log[99] - pop_log[0]), W'(99));
        else check_eq("t3_pop_log", W'(pop_log.size()), W'(100));
        check_eq("t3_busy", W'(busy), W'(1'b0));

        // Random valid/ready, 1000 beats
        key = {$urandom, $urandom, $urandom, $urandom};
        a0 = n_acc; p0 = n_pop; guard = 0;
        while ((n_acc - a0) < 1000 && guard < 20000) begin
            cycle(1'($urandom % 2), rand_beat(), 1'($urandom % 2));
            guard++;
        end
        check_eq("t4_accepted", W'(n_acc - a0), W'(1000));
        for (int i = 0; i < 200 && (n_pop - p0) < 1000; i++) cycle(1'b0, {W{1'b0}}, 1'b1);
        check_eq("t4_popped", W'(n_pop - p0), W'(1000));

        // Reset with 3 beats in the FIFO and 5 in flight
        for (int i = 0; i < 3; i++) cycle(1'b1, rand_beat(), 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b0, {W{1'b0}}, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, rand_beat(), 1'b0);
        cycle(1'b0, {W{1'b0}}, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_eq("t5_async_valid", W'(data_out_valid), W'(1'b0));
        check_eq("t5_async_data", data_out, {W{1'b0}});
        exp_q.delete();
        outstanding = 0;
        ctr_m = 128'h0;
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 20; i++) cycle(1'b0, {W{1'b0}}, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b1, rand_beat(), 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b0, {W{1'b0}}, 1'b1);

`ifdef AES_CTR_MODE_EN
        // Counter low word wraps across lanes; load and accept in the same cycle
        key = 128'h0;
        ld_req = 1'b1;
        init_req = {96'h0123456789abcdef01234567, 32'hFFFFFFFE};
        cycle(1'b0, {W{1'b0}}, 1'b1);
        ld_req = 1'b0;
        cycle(1'b1, {W{1'b0}}, 1'b1);
        cycle(1'b1, {W{1'b0}}, 1'b1);
        ld_req = 1'b1;
        init_req = {96'hfedcba9876543210fedcba98, 32'h7FFFFFFF};
        cycle(1'b1, rand_beat(), 1'b1);
        ld_req = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1'b1, rand_beat(), 1'b1);
        for (int i = 0; i < 30; i++) cycle(1'b0, {W{1'b0}}, 1'b1);
        check_eq("t6_busy", W'(busy), W'(1'b0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
